// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage with req/ack data bus; define MISALIGN_TRAP_EN to trap misaligned half/word accesses
module mem_access #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mem_rd,
   input  logic        in_mem_wr,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_aluc,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_wb_en,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_wstrb,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_wb_en,
   output logic        out_err,
   output logic        out_exc
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t r_state, w_state_nxt;
   logic [TO_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [31:0] r_aluc, w_aluc_nxt;
   logic [1:0]  r_size, w_size_nxt;
   logic        r_uns, w_uns_nxt;
   logic [4:0]  r_rd, w_rd_nxt;
   logic        r_wb_en, w_wb_en_nxt;
   logic        r_we, w_we_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [3:0]  r_wstrb, w_wstrb_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic        r_ov, w_ov_nxt;
   logic [31:0] r_od, w_od_nxt;
   logic [4:0]  r_ord, w_ord_nxt;
   logic        r_owb, w_owb_nxt;
   logic        r_oerr, w_oerr_nxt;
   logic        r_oexc, w_oexc_nxt;
   logic        w_mem, w_mis, w_to;
   logic [3:0]  w_st_strb;
   logic [31:0] w_st_data, w_ld_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_mem = in_mem_rd | in_mem_wr;
`ifdef MISALIGN_TRAP_EN
   assign w_mis = ((in_size == 2'b01) & in_aluc[0]) | (in_size[1] & (|in_aluc[1:0]));
`else
   assign w_mis = 1'b0;
`endif
   assign w_st_strb = (in_size == 2'b00) ? (4'b0001 << in_aluc[1:0]) :
                      (in_size == 2'b01) ? (in_aluc[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign w_st_data = (in_size == 2'b00) ? {4{in_wdata[7:0]}} :
                      (in_size == 2'b01) ? {2{in_wdata[15:0]}} : in_wdata;
   assign w_byte = r_aluc[1] ? (r_aluc[0] ? dbus_rdata[31:24] : dbus_rdata[23:16])
                             : (r_aluc[0] ? dbus_rdata[15:8]  : dbus_rdata[7:0]);
   assign w_half = r_aluc[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
   assign w_ld_data = (r_size == 2'b00) ? {{24{w_byte[7] & ~r_uns}}, w_byte} :
                      (r_size == 2'b01) ? {{16{w_half[15] & ~r_uns}}, w_half} : dbus_rdata;
   assign w_cnt_inc = r_cnt + TO_W'(1);
   assign w_to = (TIMEOUT != 0) && (w_cnt_inc == TO_W'(TIMEOUT));

   assign in_ready   = (r_state == IDLE);
   assign dbus_req   = (r_state == BUSY);
   assign dbus_we    = r_we;
   assign dbus_addr  = r_addr;
   assign dbus_wstrb = r_wstrb;
   assign dbus_wdata = r_wdata;
   assign out_valid  = r_ov;
   assign out_data   = r_od;
   assign out_rd     = r_ord;
   assign out_wb_en  = r_owb;
   assign out_err    = r_oerr;
   assign out_exc    = r_oexc;

   // next-state and next-output decode: accept in IDLE, retire on ack or timeout in BUSY
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_aluc_nxt  = r_aluc;
      w_size_nxt  = r_size;
      w_uns_nxt   = r_uns;
      w_rd_nxt    = r_rd;
      w_wb_en_nxt = r_wb_en;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wstrb_nxt = r_wstrb;
      w_wdata_nxt = r_wdata;
      w_ov_nxt    = 1'b0;
      w_od_nxt    = r_od;
      w_ord_nxt   = r_ord;
      w_owb_nxt   = r_owb;
      w_oerr_nxt  = 1'b0;
      w_oexc_nxt  = 1'b0;
      if (r_state == IDLE) begin
         if (in_valid && !w_mem) begin
            w_ov_nxt  = 1'b1;
            w_od_nxt  = in_aluc;
            w_ord_nxt = in_rd;
            w_owb_nxt = in_wb_en;
         end else if (in_valid && w_mis) begin
            w_ov_nxt   = 1'b1;
            w_oexc_nxt = 1'b1;
            w_od_nxt   = in_aluc;
            w_ord_nxt  = in_rd;
            w_owb_nxt  = 1'b0;
         end else if (in_valid) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = '0;
            w_aluc_nxt  = in_aluc;
            w_size_nxt  = in_size;
            w_uns_nxt   = in_unsigned;
            w_rd_nxt    = in_rd;
            w_wb_en_nxt = in_wb_en;
            w_we_nxt    = in_mem_wr;
            w_addr_nxt  = {in_aluc[31:2], 2'b00};
            w_wstrb_nxt = in_mem_wr ? w_st_strb : 4'b0000;
            w_wdata_nxt = in_mem_wr ? w_st_data : 32'd0;
         end
      end else begin
         if (dbus_ack) begin
            w_state_nxt = IDLE;
            w_ov_nxt    = 1'b1;
            w_od_nxt    = r_we ? r_aluc : w_ld_data;
            w_ord_nxt   = r_rd;
            w_owb_nxt   = r_wb_en;
         end else if (w_to) begin
            w_state_nxt = IDLE;
            w_ov_nxt    = 1'b1;
            w_oerr_nxt  = 1'b1;
            w_od_nxt    = 32'd0;
            w_ord_nxt   = r_rd;
            w_owb_nxt   = 1'b0;
         end else begin
            w_cnt_nxt = w_cnt_inc;
         end
      end
   end

   // state, request latch and output registers; reset abandons any pending access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_aluc  <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_rd    <= '0;
         r_wb_en <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wstrb <= '0;
         r_wdata <= '0;
         r_ov    <= 1'b0;
         r_od    <= '0;
         r_ord   <= '0;
         r_owb   <= 1'b0;
         r_oerr  <= 1'b0;
         r_oexc  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_aluc  <= w_aluc_nxt;
         r_size  <= w_size_nxt;
         r_uns   <= w_uns_nxt;
         r_rd    <= w_rd_nxt;
         r_wb_en <= w_wb_en_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wstrb <= w_wstrb_nxt;
         r_wdata <= w_wdata_nxt;
         r_ov    <= w_ov_nxt;
         r_od    <= w_od_nxt;
         r_ord   <= w_ord_nxt;
         r_owb   <= w_owb_nxt;
         r_oerr  <= w_oerr_nxt;
         r_oexc  <= w_oexc_nxt;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with TIMEOUT=4
module tb_mem_access;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_mem_rd = 1'b0, in_mem_wr = 1'b0;
   logic [1:0]  in_size = 2'b00;
   logic        in_unsigned = 1'b0, in_wb_en = 1'b0;
   logic [31:0] in_aluc = '0, in_wdata = '0;
   logic [4:0]  in_rd = '0;
   logic        dbus_req, dbus_we, dbus_ack = 1'b0;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
   logic [3:0]  dbus_wstrb;
   logic        out_valid, out_wb_en, out_err, out_exc;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_aluc(in_aluc), .in_wdata(in_wdata),
      .in_rd(in_rd), .in_wb_en(in_wb_en), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .out_valid(out_valid),
      .out_data(out_data), .out_rd(out_rd), .out_wb_en(out_wb_en),
      .out_err(out_err), .out_exc(out_exc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] dst);
      in_valid = 1'b1; in_mem_rd = rd; in_mem_wr = wr; in_size = sz; in_unsigned = uns;
      in_aluc = a; in_wdata = wd; in_rd = dst; in_wb_en = ~wr;
      tick;
      in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
   endtask

   task automatic ack_with(input logic [31:0] d);
      dbus_ack = 1'b1; dbus_rdata = d;
      tick;
      dbus_ack = 1'b0;
   endtask

   initial begin
      repeat (2) tick;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_req", 32'(dbus_req), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_dbus_addr", dbus_addr, 32'd0);
      chk("rst_wstrb", 32'(dbus_wstrb), 32'd0);
      rst_n = 1'b1;
      tick;
      in_valid = 1'b1; in_wb_en = 1'b1; in_rd = 5'd3;
      for (int i = 1; i <= 3; i++) begin
         in_aluc = 32'(i);
         tick;
         chk($sformatf("alu_valid%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("alu_data%0d", i), out_data, 32'(i));
         chk($sformatf("alu_req%0d", i), 32'(dbus_req), 32'd0);
      end
      in_valid = 1'b0;
      tick;
      chk("alu_idle", 32'(out_valid), 32'd0);
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 5'd7);
      chk("lb_req", 32'(dbus_req), 32'd1);
      chk("lb_ready", 32'(in_ready), 32'd0);
      chk("lb_addr", dbus_addr, 32'h0000_1000);
      chk("lb_strb", 32'(dbus_wstrb), 32'd0);
      chk("lb_we", 32'(dbus_we), 32'd0);
      tick;
      chk("lb_hold_req", 32'(dbus_req), 32'd1);
      chk("lb_no_valid", 32'(out_valid), 32'd0);
      ack_with(32'h80FF_0000);
      chk("lb_valid", 32'(out_valid), 32'd1);
      chk("lb_data", out_data, 32'hFFFF_FF80);
      chk("lb_rd", 32'(out_rd), 32'd7);
      chk("lb_wb", 32'(out_wb_en), 32'd1);
      chk("lb_req_off", 32'(dbus_req), 32'd0);
      issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 5'd8);
      ack_with(32'h80FF_0000);
      chk("lbu_valid", 32'(out_valid), 32'd1);
      chk("lbu_data", out_data, 32'h0000_0080);
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
      chk("sh_addr", dbus_addr, 32'h0000_2000);
      chk("sh_strb", 32'(dbus_wstrb), 32'hC);
      chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
      chk("sh_we", 32'(dbus_we), 32'd1);
      tick;
      chk("sh_hold_req", 32'(dbus_req), 32'd1);
      chk("sh_hold_wdata", dbus_wdata, 32'hABCD_ABCD);
      ack_with(32'd0);
      chk("sh_valid", 32'(out_valid), 32'd1);
      chk("sh_data", out_data, 32'h0000_2002);
      chk("sh_wb", 32'(out_wb_en), 32'd0);
      chk("sh_req_off", 32'(dbus_req), 32'd0);
      issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h0000_00EF, 5'd0);
      chk("sb_strb", 32'(dbus_wstrb), 32'h2);
      chk("sb_wdata", dbus_wdata, 32'hEFEF_EFEF);
      ack_with(32'd0);
      issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'd0, 5'd4);
      ack_with(32'h8001_7FFF);
      chk("lh_data", out_data, 32'hFFFF_8001);
      issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_6000, 32'd0, 5'd4);
      ack_with(32'h8001_7FFF);
      chk("lhu_data", out_data, 32'h0000_7FFF);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, 5'd9);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("to_req%0d", k), 32'(dbus_req), 32'd1);
         chk($sformatf("to_no_valid%0d", k), 32'(out_valid), 32'd0);
      end
      tick;
      chk("to_req_drop", 32'(dbus_req), 32'd0);
      chk("to_valid", 32'(out_valid), 32'd1);
      chk("to_err", 32'(out_err), 32'd1);
      chk("to_wb", 32'(out_wb_en), 32'd0);
      chk("to_data", out_data, 32'd0);
      chk("to_ready", 32'(in_ready), 32'd1);
      tick;
      chk("to_err_clear", 32'(out_err), 32'd0);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'd0, 5'd9);
      repeat (3) tick;
      ack_with(32'hDEAD_BEEF);
      chk("ackwin_valid", 32'(out_valid), 32'd1);
      chk("ackwin_err", 32'(out_err), 32'd0);
      chk("ackwin_data", out_data, 32'hDEAD_BEEF);
      chk("ackwin_wb", 32'(out_wb_en), 32'd1);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 5'd2);
      chk("rr_req", 32'(dbus_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rr_req_async", 32'(dbus_req), 32'd0);
      tick;
      chk("rr_no_valid", 32'(out_valid), 32'd0);
      chk("rr_ready", 32'(in_ready), 32'd1);
      #2 rst_n = 1'b1;
      tick;
      chk("rr_no_valid2", 32'(out_valid), 32'd0);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 5'd2);
      chk("rr_addr", dbus_addr, 32'h0000_0010);
      ack_with(32'h1122_3344);
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_data", out_data, 32'h1122_3344);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 5'd10);
`ifdef MISALIGN_TRAP_EN
      chk("ma_valid", 32'(out_valid), 32'd1);
      chk("ma_exc", 32'(out_exc), 32'd1);
      chk("ma_wb", 32'(out_wb_en), 32'd0);
      chk("ma_data", out_data, 32'h0000_3001);
      chk("ma_req", 32'(dbus_req), 32'd0);
`else
      chk("ma_req", 32'(dbus_req), 32'd1);
      chk("ma_addr", dbus_addr, 32'h0000_3000);
      ack_with(32'hCAFE_F00D);
      chk("ma_valid", 32'(out_valid), 32'd1);
      chk("ma_data", out_data, 32'hCAFE_F00D);
      chk("ma_exc", 32'(out_exc), 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
